// File: rtl/gpio_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_cfg_sequencer
//
// Walks the pad configuration register bank from pad NUM_PADS-1 down to
// pad 0, shifting each CFG_BITS-wide word MSB first into the serial pad
// control chain, then pulses serial_load so the pads latch the new setup.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   RSTB         synchronous reset, active high
//   start        single-cycle request to load the whole chain
//   abort        stop a transfer in progress (chain left partially shifted)
//   cfg_addr     pad index presented to the configuration register bank
//   cfg_rdata    configuration word for cfg_addr, valid 1 cycle after change
//   serial_clock shift clock to the chain (registered)
//   serial_data  shift data, sampled by the chain on serial_clock rise
//   serial_load  transfer strobe into the pad latches (registered)
//   busy         high in FETCH, SHIFT and LOAD
//   done         one-cycle pulse on successful completion
// ---------------------------------------------------------------------------
module gpio_cfg_sequencer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                clock,
    input  logic                RSTB,
    input  logic                start,
    input  logic                abort,
    output logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);

    localparam int              BW         = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [7:0]      DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [5:0]      LAST_PAD   = 6'(NUM_PADS - 1);
    localparam logic [BW-1:0]   LAST_BIT   = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          addr_q,  addr_d;
    logic [BW-1:0]       bit_q,   bit_d;
    logic [CFG_BITS-1:0] word_q,  word_d;
    logic [7:0]          div_q,   div_d;
    // Second-cycle marker: FETCH uses it for the bank read latency,
    // LOAD uses it to split the 2*CLK_DIV strobe into two 8-bit-countable halves.
    logic                step_q,  step_d;
    logic                sclk_q,  sclk_d;
    logic                sdata_q, sdata_d;
    logic                sload_q, sload_d;

    always_ff @(posedge clock) begin
        if (RSTB) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            div_q   <= '0;
            step_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            sload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            div_q   <= div_d;
            step_q  <= step_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            sload_q <= sload_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        word_d  = word_q;
        div_d   = div_q;
        step_d  = step_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        sload_d = sload_q;

        case (state_q)
            IDLE: begin
                div_d   = '0;
                step_d  = 1'b0;
                sclk_d  = 1'b0;
                sload_d = 1'b0;
                if (start && !abort) begin
                    state_d = FETCH;
                    addr_d  = LAST_PAD;
                    bit_d   = LAST_BIT;
                end
            end

            FETCH: begin
                div_d = '0;
                if (abort) begin
                    state_d = IDLE;
                    step_d  = 1'b0;
                    sclk_d  = 1'b0;
                    sload_d = 1'b0;
                end else if (!step_q) begin
                    step_d = 1'b1;
                end else begin
                    // Bank output is valid now; first bit goes out with the low phase.
                    step_d  = 1'b0;
                    word_d  = cfg_rdata;
                    sdata_d = cfg_rdata[CFG_BITS-1];
                    div_d   = DIV_RELOAD;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    sload_d = 1'b0;
                end else if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    div_d  = DIV_RELOAD;
                end else begin
                    // End of high phase: falling edge is where data may change.
                    sclk_d = 1'b0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        word_d  = word_q << 1;
                        sdata_d = word_q[CFG_BITS-2];
                        div_d   = DIV_RELOAD;
                    end else if (addr_q != 6'd0) begin
                        addr_d  = addr_q - 6'd1;
                        bit_d   = LAST_BIT;
                        div_d   = '0;
                        state_d = FETCH;
                    end else begin
                        sload_d = 1'b1;
                        step_d  = 1'b0;
                        div_d   = DIV_RELOAD;
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    div_d   = '0;
                    step_d  = 1'b0;
                    sclk_d  = 1'b0;
                    sload_d = 1'b0;
                end else if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (!step_q) begin
                    step_d = 1'b1;
                    div_d  = DIV_RELOAD;
                end else begin
                    step_d  = 1'b0;
                    sload_d = 1'b0;
                    div_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                div_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_addr     = addr_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = sload_q;
    assign busy         = (state_q == FETCH) || (state_q == SHIFT) || (state_q == LOAD);
    assign done         = (state_q == DONE);

endmodule
